// File: rtl/gpio_irq_if.sv
// APB3 completer-side signal bundle for the GPIO block.
// Pure wiring, no latency of its own.
// pready is driven by the completer; this block never stalls the bus.
interface gpio_irq_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );
endinterface

// File: rtl/gpio_irq.sv
// APB GPIO with atomic SET/CLR/XOR aliases, input synchroniser and per-pin edge/level interrupts.
// Latency: writes commit on the access-phase edge; inputs reach IN after SYNC_STAGES edges; irq is registered.
// Backpressure: none, pready is tied high (zero wait states).
module gpio_irq #(
    parameter int N_GPIOS     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    gpio_irq_if.slave          apbs,
    output logic [N_GPIOS-1:0] o,
    output logic [N_GPIOS-1:0] oe,
    input  logic [N_GPIOS-1:0] i,
    output logic               irq
);

    localparam logic [3:0] A_OUT     = 4'd0;
    localparam logic [3:0] A_OUT_SET = 4'd1;
    localparam logic [3:0] A_OUT_CLR = 4'd2;
    localparam logic [3:0] A_OUT_XOR = 4'd3;
    localparam logic [3:0] A_OE      = 4'd4;
    localparam logic [3:0] A_OE_SET  = 4'd5;
    localparam logic [3:0] A_OE_CLR  = 4'd6;
    localparam logic [3:0] A_OE_XOR  = 4'd7;
    localparam logic [3:0] A_IN      = 4'd8;
    localparam logic [3:0] A_INTE    = 4'd9;
    localparam logic [3:0] A_INTTYPE = 4'd10;
    localparam logic [3:0] A_INTPOL  = 4'd11;
    localparam logic [3:0] A_INTSTAT = 4'd12;

    logic [N_GPIOS-1:0] out_q, out_d;
    logic [N_GPIOS-1:0] oe_q, oe_d;
    logic [N_GPIOS-1:0] inte_q, inte_d;
    logic [N_GPIOS-1:0] inttype_q, inttype_d;
    logic [N_GPIOS-1:0] intpol_q, intpol_d;
    logic [N_GPIOS-1:0] edge_q, edge_d;
    logic [SYNC_STAGES-1:0][N_GPIOS-1:0] sync_q;
    logic [N_GPIOS-1:0] in_d_q;
    logic               irq_q, irq_d;

    logic [3:0]         idx;
    logic               access;
    logic               bad;
    logic               wr;
    logic [N_GPIOS-1:0] wd;
    logic [N_GPIOS-1:0] in_s;
    logic [N_GPIOS-1:0] sel_edge;
    logic [N_GPIOS-1:0] intstat;
    logic [N_GPIOS-1:0] rd_val;
    logic [31:0]        rd_word;

    // Only paddr[5:2] is decoded and only the low N_GPIOS data bits are stored.
    logic unused_apb;
    assign unused_apb = ^{apbs.paddr[15:6], apbs.paddr[1:0], apbs.pwdata};

    assign idx    = apbs.paddr[5:2];
    assign access = apbs.psel & apbs.penable;
    // Unmapped offsets and writes to the read-only input register are rejected.
    assign bad    = (idx >= 4'd13) | (apbs.pwrite & (idx == A_IN));
    assign wr     = access & apbs.pwrite & ~bad;
    assign wd     = apbs.pwdata[N_GPIOS-1:0];

    assign in_s     = sync_q[SYNC_STAGES-1];
    assign sel_edge = (intpol_q & in_s & ~in_d_q) | (~intpol_q & ~in_s & in_d_q);
    // Edge pins report the sticky bit, level pins report the live (polarity-adjusted) input.
    assign intstat  = (inttype_q & edge_q) | (~inttype_q & ~(in_s ^ intpol_q));

    assign o                = out_q;
    assign oe               = oe_q;
    assign irq              = irq_q;
    assign apbs.pready      = 1'b1;
    assign apbs.pslverr     = access & bad;
    assign apbs.prdata      = (apbs.psel & ~bad) ? rd_word : 32'd0;

    // Register write decode, sticky edge status and interrupt line next state.
    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        inte_d    = inte_q;
        inttype_d = inttype_q;
        intpol_d  = intpol_q;
        if (wr) begin
            case (idx)
                A_OUT:     out_d     = wd;
                A_OUT_SET: out_d     = out_q | wd;
                A_OUT_CLR: out_d     = out_q & ~wd;
                A_OUT_XOR: out_d     = out_q ^ wd;
                A_OE:      oe_d      = wd;
                A_OE_SET:  oe_d      = oe_q | wd;
                A_OE_CLR:  oe_d      = oe_q & ~wd;
                A_OE_XOR:  oe_d      = oe_q ^ wd;
                A_INTE:    inte_d    = wd;
                A_INTTYPE: inttype_d = wd;
                A_INTPOL:  intpol_d  = wd;
                default:   ;
            endcase
        end
        // A new edge beats a same-cycle W1C; leaving edge mode drops the sticky bit.
        edge_d = ((edge_q & ~((wr && idx == A_INTSTAT) ? wd : '0)) | sel_edge) & inttype_d;
        irq_d  = |(intstat & inte_q);
    end

    // Read-data mux, zero-extended to the bus width; aliases read as zero.
    always_comb begin
        rd_val = '0;
        case (idx)
            A_OUT:     rd_val = out_q;
            A_OE:      rd_val = oe_q;
            A_IN:      rd_val = in_s;
            A_INTE:    rd_val = inte_q;
            A_INTTYPE: rd_val = inttype_q;
            A_INTPOL:  rd_val = intpol_q;
            A_INTSTAT: rd_val = intstat;
            default:   rd_val = '0;
        endcase
        rd_word                = '0;
        rd_word[N_GPIOS-1:0]   = rd_val;
    end

    // State registers, input synchroniser and delay flop, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            oe_q      <= '0;
            inte_q    <= '0;
            inttype_q <= '0;
            intpol_q  <= '0;
            edge_q    <= '0;
            sync_q    <= '0;
            in_d_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            inte_q    <= inte_d;
            inttype_q <= inttype_d;
            intpol_q  <= intpol_d;
            edge_q    <= edge_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i};
            in_d_q    <= in_s;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_gpio_irq.sv
// Scoreboard bench for gpio_irq: stimulus pushes expectations, a negedge monitor pops and compares.
// Expectations are hand-computed for N_GPIOS=8, SYNC_STAGES=2.
// APB accesses and pin probes are compared in the order they are issued.
module tb_gpio_irq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] o;
    logic [7:0] oe;
    logic [7:0] pins;
    logic       irq;

    gpio_irq_if apbs();

    gpio_irq #(.N_GPIOS(8), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .apbs (apbs),
        .o    (o),
        .oe   (oe),
        .i    (pins),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    // kind: 0 = APB access, 1 = o, 2 = oe, 3 = irq, 4 = prdata while idle
    typedef struct {
        int          kind;
        string       nm;
        logic [31:0] dat;
        logic        err;
        logic        chk_dat;
    } exp_t;

    exp_t sb[$];
    int   probe_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        probe_cnt = 0;
    endtask

    task automatic probe(input int kind, input string nm, input logic [31:0] v);
        exp_t e;
        e.kind = kind; e.nm = nm; e.dat = v; e.err = 1'b0; e.chk_dat = 1'b1;
        sb.push_back(e);
        probe_cnt++;
    endtask

    task automatic apb(input logic w, input logic [15:0] a, input logic [31:0] wdat,
                       input logic [31:0] exp_rd, input logic exp_err, input string nm);
        exp_t e;
        apbs.psel = 1'b1; apbs.penable = 1'b0; apbs.pwrite = w;
        apbs.paddr = a; apbs.pwdata = wdat;
        tick();
        apbs.penable = 1'b1;
        e.kind = 0; e.nm = nm; e.dat = exp_rd; e.err = exp_err; e.chk_dat = !w || exp_err;
        sb.push_back(e);
        tick();
        apbs.psel = 1'b0; apbs.penable = 1'b0; apbs.pwrite = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input string nm);
        apb(1'b1, a, d, 32'd0, 1'b0, nm);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] exp_rd, input string nm);
        apb(1'b0, a, 32'd0, exp_rd, 1'b0, nm);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp_v);
        end
    endtask

    // Monitor: an APB access phase or a pending probe is the DUT response to compare.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (apbs.psel && apbs.penable) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_access: scoreboard empty");
            end else begin
                e = sb.pop_front();
                if (e.kind != 0) begin
                    n_vec++; n_err++;
                    $display("FAIL %s: got APB access, want probe kind %0d", e.nm, e.kind);
                end else begin
                    check({e.nm, "_pslverr"}, {31'd0, apbs.pslverr}, {31'd0, e.err});
                    if (e.chk_dat) check({e.nm, "_prdata"}, apbs.prdata, e.dat);
                end
            end
        end
        for (int k = 0; k < probe_cnt; k++) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL probe_underflow: scoreboard empty");
            end else begin
                e = sb.pop_front();
                case (e.kind)
                    1:       act = {24'd0, o};
                    2:       act = {24'd0, oe};
                    3:       act = {31'd0, irq};
                    4:       act = apbs.prdata;
                    default: act = 32'hDEAD_BEEF;
                endcase
                check(e.nm, act, e.dat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pins = 8'h00;
        apbs.psel = 1'b0; apbs.penable = 1'b0; apbs.pwrite = 1'b0;
        apbs.paddr = 16'd0; apbs.pwdata = 32'd0;
        tick(); tick();
        probe(1, "rst_o", 0); probe(2, "rst_oe", 0); probe(3, "rst_irq", 0); probe(4, "rst_prdata", 0);
        tick();
        rst = 1'b0;
        tick();

        // Reset contents; level pins with polarity low and inputs low report 1.
        for (int k = 0; k < 12; k++) rd(16'(k * 4), 32'd0, "rst_reg");
        rd(16'h30, 32'hFF, "rst_intstat");

        // Atomic output access.
        wr(16'h00, 32'hA5, "out_wr");
        wr(16'h04, 32'h02, "out_set");
        wr(16'h08, 32'h80, "out_clr");
        wr(16'h0C, 32'h0F, "out_xor");
        probe(1, "o_atomic", 32'h28);
        rd(16'h00, 32'h28, "out_rd");
        wr(16'h00, 32'hFFFF_FF28, "out_hi_wr");
        rd(16'h00, 32'h28, "out_hi_rd");
        rd(16'h0C, 32'h0, "alias_rd");
        wr(16'h14, 32'h3C, "oe_set");
        wr(16'h1C, 32'hFF, "oe_xor");
        wr(16'h18, 32'h41, "oe_clr");
        probe(2, "oe_atomic", 32'h82);
        rd(16'h10, 32'h82, "oe_rd");

        // Rising-edge interrupt on pin 0.
        wr(16'h28, 32'h01, "type_edge0");
        wr(16'h2C, 32'h01, "pol_rise0");
        rd(16'h30, 32'hFE, "stat_pre");
        wr(16'h24, 32'h01, "inte0");
        pins[0] = 1'b1;
        rd(16'h30, 32'hFE, "stat_e1");
        probe(3, "irq_e2", 0);
        rd(16'h30, 32'hFF, "stat_e3");
        probe(3, "irq_e4", 1);
        rd(16'h20, 32'h01, "in_rd");
        wr(16'h30, 32'h01, "w1c");
        probe(3, "irq_w1c_lag", 1);
        tick();
        probe(3, "irq_w1c", 0);
        rd(16'h30, 32'hFE, "stat_w1c");

        // W1C landing on the same edge as a new rising edge.
        pins[0] = 1'b0;
        repeat (4) tick();
        pins[0] = 1'b1;
        repeat (5) tick();
        probe(3, "irq_pre_col", 1);
        pins[0] = 1'b0;
        repeat (4) tick();
        pins[0] = 1'b1;
        tick();
        wr(16'h30, 32'h01, "w1c_collide");
        probe(3, "irq_collide", 1);
        rd(16'h30, 32'hFF, "stat_collide");
        probe(3, "irq_collide2", 1);

        // Edge-to-level switch discards the sticky bit.
        pins[3] = 1'b1;
        repeat (4) tick();
        wr(16'h28, 32'h00, "type_level");
        wr(16'h2C, 32'h00, "pol_low");
        wr(16'h24, 32'h08, "inte3");
        wr(16'h28, 32'h01, "type_edge_again");
        rd(16'h30, 32'hF6, "stat_discard");
        wr(16'h28, 32'h00, "type_level2");
        rd(16'h30, 32'hF6, "stat_level");
        probe(3, "irq_lvl_idle", 0);

        // Active-low level interrupt on pin 3.
        pins[3] = 1'b0;
        tick(); tick();
        probe(3, "irq_lvl_e2", 0);
        tick();
        probe(3, "irq_lvl_e3", 1);
        rd(16'h30, 32'hFE, "stat_lvl_act");
        wr(16'h30, 32'h08, "lvl_w1c");
        probe(3, "irq_lvl_w1c", 1);
        rd(16'h30, 32'hFE, "stat_lvl_w1c");
        pins[3] = 1'b1;
        tick(); tick();
        probe(3, "irq_lvl_off_e2", 1);
        tick();
        probe(3, "irq_lvl_off_e3", 0);

        // Error responses leave state untouched.
        apb(1'b1, 16'h34, 32'hFF, 32'd0, 1'b1, "err_wr34");
        apb(1'b1, 16'h20, 32'hFF, 32'd0, 1'b1, "err_wr_in");
        apb(1'b0, 16'h3C, 32'd0, 32'd0, 1'b1, "err_rd3c");
        rd(16'h00, 32'h28, "out_kept");
        rd(16'h10, 32'h82, "oe_kept");
        rd(16'h20, 32'h09, "in_pins");
        wr(16'h0100, 32'h33, "upper_addr_wr");
        probe(1, "o_upper_addr", 32'h33);
        probe(4, "idle_prdata", 0);
        tick();

        // Asynchronous reset clears outputs without a clock edge.
        rst = 1'b1;
        probe(1, "arst_o", 0);
        probe(2, "arst_oe", 0);
        tick();
        rst = 1'b0;
        tick();

        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
